// File: rtl/data_memory_responder_if.sv
// MEM-stage data-memory bus between the EX/MEM register and the responder.
// The master drives requests; the slave returns data, ack, busy and misaligned.
interface data_memory_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        misaligned;

    modport master (
        output mem_read, mem_write, funct3, addr, wdata,
        input  rdata, ack, busy, misaligned
    );

    modport slave (
        input  mem_read, mem_write, funct3, addr, wdata,
        output rdata, ack, busy, misaligned
    );
endinterface

// File: rtl/data_memory_responder.sv
// Slow data-memory responder: word array served after WAIT_STATES wait cycles.
// Optional MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of aligning them.
module data_memory_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    data_memory_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;

    logic [31:0] mem_q [DEPTH];

    logic          req;
    logic          enter_resp;
    logic [AW-1:0] widx;
    logic [31:0]   ld_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_fmt;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic          st_en;
    logic          mis_now;
    logic          unused_addr;

    assign req         = bus.mem_read | bus.mem_write;
    assign widx        = bus.addr[AW+1:2];
    assign unused_addr = ^bus.addr[31:AW+2];
    assign ld_word     = mem_q[widx];
    assign ld_byte     = 8'(ld_word >> {bus.addr[1:0], 3'b000});
    assign ld_half     = bus.addr[1] ? ld_word[31:16] : ld_word[15:0];

    always_comb begin
        ld_fmt = ld_word;
        unique case (bus.funct3)
            3'b000: ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_fmt = {24'd0, ld_byte};
            3'b001: ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101: ld_fmt = {16'd0, ld_half};
            default: ld_fmt = ld_word;
        endcase
    end

    always_comb begin
        st_be   = 4'b1111;
        st_data = bus.wdata;
        unique case (bus.funct3)
            3'b000: begin
                st_be   = 4'b0001 << bus.addr[1:0];
                st_data = {4{bus.wdata[7:0]}};
            end
            3'b001: begin
                st_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = bus.wdata;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic acc_byte;
    logic acc_half;
    // Store and load share funct3 codes but not their width decode.
    always_comb begin
        acc_byte = 1'b0;
        acc_half = 1'b0;
        if (bus.mem_write) begin
            acc_byte = (bus.funct3 == 3'b000);
            acc_half = (bus.funct3 == 3'b001);
        end else begin
            acc_byte = (bus.funct3[1:0] == 2'b00);
            acc_half = (bus.funct3[1:0] == 2'b01);
        end
        mis_now = (acc_half & bus.addr[0])
                | (~acc_byte & ~acc_half & (|bus.addr[1:0]));
    end
`else
    assign mis_now = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    always_comb begin
        rdata_d = rdata_q;
        mis_d   = mis_q;
        if (enter_resp) begin
            mis_d = mis_now;
            if (bus.mem_read && !bus.mem_write) begin
                rdata_d = mis_now ? 32'd0 : ld_fmt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Stores commit as the pipe advances past the ack cycle.
    assign st_en = (state_q == RESP) && bus.mem_write && !reset && !mis_q;

    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem_q[widx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.rdata      = rdata_q;
    assign bus.ack        = (state_q == RESP);
    assign bus.busy       = req && (state_q != RESP);
    assign bus.misaligned = (state_q == RESP) && mis_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// Random and directed bench for data_memory_responder against a byte-level model.
// Two instances: A (2 wait states, 1024 words) and B (0 wait states, 16 words).
module tb_data_memory_responder;
    localparam int WS_A    = 2;
    localparam int DEPTH_A = 1024;
    localparam int WS_B    = 0;
    localparam int DEPTH_B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic        rd_r   [2];
    logic        wr_r   [2];
    logic [2:0]  f3_r   [2];
    logic [31:0] addr_r [2];
    logic [31:0] wd_r   [2];
    logic [31:0] rdata_w[2];
    logic        ack_w  [2];
    logic        busy_w [2];
    logic        mis_w  [2];

    data_memory_responder_if if_a ();
    data_memory_responder_if if_b ();

    assign if_a.mem_read  = rd_r[0];
    assign if_a.mem_write = wr_r[0];
    assign if_a.funct3    = f3_r[0];
    assign if_a.addr      = addr_r[0];
    assign if_a.wdata     = wd_r[0];
    assign rdata_w[0]     = if_a.rdata;
    assign ack_w[0]       = if_a.ack;
    assign busy_w[0]      = if_a.busy;
    assign mis_w[0]       = if_a.misaligned;

    assign if_b.mem_read  = rd_r[1];
    assign if_b.mem_write = wr_r[1];
    assign if_b.funct3    = f3_r[1];
    assign if_b.addr      = addr_r[1];
    assign if_b.wdata     = wd_r[1];
    assign rdata_w[1]     = if_b.rdata;
    assign ack_w[1]       = if_b.ack;
    assign busy_w[1]      = if_b.busy;
    assign mis_w[1]       = if_b.misaligned;

    data_memory_responder #(.DEPTH(DEPTH_A), .WAIT_STATES(WS_A)) u_a (
        .clk   (clk),
        .reset (rst[0]),
        .bus   (if_a)
    );

    data_memory_responder #(.DEPTH(DEPTH_B), .WAIT_STATES(WS_B)) u_b (
        .clk   (clk),
        .reset (rst[1]),
        .bus   (if_b)
    );

    int n_checks = 0;
    int n_err    = 0;

    int          depth_of [2] = '{DEPTH_A, DEPTH_B};
    int          ws_of    [2] = '{WS_A, WS_B};
    logic [31:0] mm       [2][DEPTH_A];
    logic [31:0] last_rd  [2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-level reference: width from funct3, lanes from the low address bits.
    function automatic void model(input int d, input bit wr, input bit rd,
                                  input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd,
                                  output logic [31:0] er, output bit em);
        int     idx;
        int     n;
        int     base;
        longint mask;
        longint v;
        idx = int'(a >> 2) % depth_of[d];
        if (wr) n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else    n = (f3 == 3'd0 || f3 == 3'd4) ? 1
                  : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        em = 1'b0;
`ifdef MISALIGN_TRAP_EN
        em = (int'(a[1:0]) % n) != 0;
`endif
        base = (int'(a[1:0]) / n) * n;
        mask = (64'd1 << (8 * n)) - 1;
        er   = last_rd[d];
        if (wr) begin
            if (!em) begin
                for (int i = 0; i < n; i++)
                    mm[d][idx][8*(base+i) +: 8] = wd[8*i +: 8];
            end
        end else if (rd) begin
            v = em ? 64'd0 : ({32'd0, mm[d][idx]} >> (8 * base)) & mask;
            if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v | ~mask;
            er = v[31:0];
            last_rd[d] = er;
        end
    endfunction

    task automatic idle_bus(input int d);
        rd_r[d]   = 1'b0;
        wr_r[d]   = 1'b0;
        f3_r[d]   = 3'd0;
        addr_r[d] = 32'd0;
        wd_r[d]   = 32'd0;
    endtask

    // Called on a falling edge; returns one cycle after ack with the bus idle.
    task automatic acc(input int d, input bit wr, input bit rd,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
        int          cyc;
        int          bcnt;
        bit          got;
        logic [31:0] er;
        bit          em;
        model(d, wr, rd, f3, a, wd, er, em);
        rd_r[d] = rd; wr_r[d] = wr; f3_r[d] = f3;
        addr_r[d] = a; wd_r[d] = wd;
        cyc = 0; bcnt = 0; got = 0;
        while (!got && cyc < 40) begin
            #1;
            if (ack_w[d]) begin
                got = 1;
            end else begin
                if (busy_w[d]) bcnt++;
                cyc++;
                @(negedge clk);
            end
        end
        check({tag, " ack_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, " latency"}, cyc, ws_of[d] + 1);
            check({tag, " busy_cycles"}, bcnt, ws_of[d] + 1);
            check({tag, " busy_on_ack"}, 32'(busy_w[d]), 32'd0);
            check({tag, " rdata"}, rdata_w[d], er);
            check({tag, " misaligned"}, 32'(mis_w[d]), 32'(em));
        end
        @(negedge clk);
        idle_bus(d);
        #1;
        check({tag, " ack_single"}, 32'(ack_w[d]), 32'd0);
    endtask

    task automatic rand_acc(input int d, input int nwords, input string tag);
        int          kind;
        logic [31:0] a;
        logic [31:0] hi_mask;
        hi_mask = (d == 0) ? 32'hFFFF_F000 : 32'hFFFF_FFC0;
        kind = $urandom_range(0, 2);
        a = 32'($urandom_range(0, nwords - 1) * 4 + $urandom_range(0, 3));
        a = a | ($urandom & hi_mask);
        acc(d, kind != 0, kind != 1, 3'($urandom_range(0, 7)), a,
            $urandom, tag);
    endtask

    initial begin
        logic [31:0] er;
        bit          em;
        rst[0] = 1'b1; rst[1] = 1'b1;
        idle_bus(0); idle_bus(1);
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        repeat (3) @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;
        #1;
        check("reset_rdata_a", rdata_w[0], 32'd0);
        check("reset_ack_a", 32'(ack_w[0]), 32'd0);
        check("reset_busy_a", 32'(busy_w[0]), 32'd0);
        check("reset_mis_a", 32'(mis_w[0]), 32'd0);
        check("reset_rdata_b", rdata_w[1], 32'd0);
        check("reset_ack_b", 32'(ack_w[1]), 32'd0);
        @(negedge clk);

        acc(0, 1, 0, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw_10");
        acc(0, 0, 1, 3'b000, 32'h13, 32'd0, "lb_13");
        check("lb_13_const", last_rd[0], 32'hFFFF_FFDE);
        acc(0, 0, 1, 3'b100, 32'h13, 32'd0, "lbu_13");
        check("lbu_13_const", last_rd[0], 32'h0000_00DE);
        acc(0, 0, 1, 3'b001, 32'h12, 32'd0, "lh_12");
        check("lh_12_const", last_rd[0], 32'hFFFF_DEAD);
        acc(0, 1, 0, 3'b000, 32'h11, 32'h0000_0055, "sb_11");
        acc(0, 0, 1, 3'b010, 32'h10, 32'd0, "lw_10");
        check("lw_10_const", last_rd[0], 32'hDEAD_55EF);

        for (int w = 0; w < 64; w++)
            if (w != 4) acc(0, 1, 0, 3'b010, 32'(w * 4), $urandom, "init_a");

        // Request withdrawn mid-wait: no ack, no write.
        rd_r[0] = 1'b0; wr_r[0] = 1'b1; f3_r[0] = 3'b010;
        addr_r[0] = 32'h30; wd_r[0] = 32'hA5A5_A5A5;
        @(negedge clk);
        idle_bus(0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("drop_no_ack", 32'(ack_w[0]), 32'd0);
            @(negedge clk);
        end
        acc(0, 0, 1, 3'b010, 32'h30, 32'd0, "drop_lw_30");

        // Reset during WAIT aborts the store and clears rdata.
        rd_r[0] = 1'b0; wr_r[0] = 1'b1; f3_r[0] = 3'b010;
        addr_r[0] = 32'h20; wd_r[0] = 32'h1234_5678;
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        idle_bus(0);
        last_rd[0] = 32'd0;
        #1;
        check("rst_wait_ack", 32'(ack_w[0]), 32'd0);
        check("rst_wait_rdata", rdata_w[0], 32'd0);
        @(negedge clk);
        acc(0, 0, 1, 3'b010, 32'h20, 32'd0, "rst_lw_20");

        acc(0, 1, 0, 3'b010, 32'h22, 32'hCAFE_F00D, "sw_22");
        acc(0, 0, 1, 3'b010, 32'h20, 32'd0, "lw_20_after_22");
        model(0, 0, 1, 3'b010, 32'h20, 32'd0, er, em);
`ifdef MISALIGN_TRAP_EN
        check("sw_22_effect", er, last_rd[0]);
`else
        check("sw_22_effect", er, 32'hCAFE_F00D);
`endif
        acc(0, 1, 1, 3'b010, 32'h24, 32'h0BAD_CAFE, "rw_both");
        acc(0, 0, 1, 3'b010, 32'h1_0024, 32'd0, "wrap_lw");

        for (int i = 0; i < 200; i++) rand_acc(0, 64, "rand_a");

        for (int w = 0; w < DEPTH_B; w++)
            acc(1, 1, 0, 3'b010, 32'(w * 4), $urandom, "init_b");
        acc(1, 0, 1, 3'b010, 32'h0, 32'd0, "b2b_lw_0");
        acc(1, 0, 1, 3'b010, 32'h4, 32'd0, "b2b_lw_4");
        for (int i = 0; i < 150; i++) rand_acc(1, DEPTH_B, "rand_b");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end
endmodule
